// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, checks
// framing and CRC7, hands index/argument to a local controller, and sends
// the controller's 48-bit response back after the Ncr gap. Everything runs
// on clk_i; sd_clk_en_i marks each SD clock rising edge.
`timescale 1ns/1ps

module sd_card_cmd_responder #(
  parameter int NcrCycles        = 2,
  parameter int RspTimeoutCycles = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sd_clk_en_i,
  input  logic        sd_cmd_i,
  output logic        sd_cmd_o,
  output logic        sd_cmd_en_o,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        cmd_err_o,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic [5:0]  rsp_index_i,
  input  logic [31:0] rsp_arg_i,
  output logic        busy_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RX       = 3'd1;
  localparam logic [2:0] CHECK    = 3'd2;
  localparam logic [2:0] WAIT_RSP = 3'd3;
  localparam logic [2:0] TX       = 3'd4;

  localparam int              TmoW     = $clog2(RspTimeoutCycles + 1);
  localparam logic [6:0]      NcrStart = 7'(NcrCycles - 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(RspTimeoutCycles);

  // One CRC7 step, polynomial x^7 + x^3 + 1, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  logic [2:0]      state_reg, state_next;
  logic [5:0]      bit_cnt_reg, bit_cnt_next;
  logic [47:0]     rx_shift_reg, rx_shift_next;
  logic [5:0]      cmd_index_reg, cmd_index_next;
  logic [31:0]     cmd_arg_reg, cmd_arg_next;
  logic            cmd_valid_reg, cmd_valid_next;
  logic            cmd_err_reg, cmd_err_next;
  logic [6:0]      ncr_cnt_reg, ncr_cnt_next;
  logic [TmoW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic            rsp_latched_reg, rsp_latched_next;
  logic [47:0]     rsp_frame_reg, rsp_frame_next;
  logic [47:0]     tx_shift_reg, tx_shift_next;
  logic [5:0]      tx_cnt_reg, tx_cnt_next;

  // CRC chains over the first 40 frame bits: one for the received command,
  // one for the response body offered by the controller.
  logic [6:0]  rx_crc_chain [0:40];
  logic [6:0]  tx_crc_chain [0:40];
  logic [39:0] tx_body;

  assign tx_body         = {2'b00, rsp_index_i, rsp_arg_i};
  assign rx_crc_chain[0] = 7'd0;
  assign tx_crc_chain[0] = 7'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 40; gi++) begin : g_crc
      assign rx_crc_chain[gi+1] = crc7_step(rx_crc_chain[gi], rx_shift_reg[47-gi]);
      assign tx_crc_chain[gi+1] = crc7_step(tx_crc_chain[gi], tx_body[39-gi]);
    end
  endgenerate

  logic cmd_ok;
  logic start_cmd;
  logic rsp_fire;

  assign cmd_ok    = rx_shift_reg[46] && (rx_shift_reg[7:1] == rx_crc_chain[40]) && rx_shift_reg[0];
  assign start_cmd = sd_clk_en_i && !sd_cmd_i;
  assign rsp_fire  = (state_reg == WAIT_RSP) && !rsp_latched_reg && rsp_valid_i;

  // Next-state and datapath decisions for the command/response FSM.
  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    rx_shift_next    = rx_shift_reg;
    cmd_index_next   = cmd_index_reg;
    cmd_arg_next     = cmd_arg_reg;
    cmd_valid_next   = 1'b0;
    cmd_err_next     = 1'b0;
    ncr_cnt_next     = ncr_cnt_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    rsp_latched_next = rsp_latched_reg;
    rsp_frame_next   = rsp_frame_reg;
    tx_shift_next    = tx_shift_reg;
    tx_cnt_next      = tx_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start_cmd) begin
          state_next    = RX;
          bit_cnt_next  = 6'd1;
          rx_shift_next = 48'd0;
        end
      end

      RX: begin
        if (sd_clk_en_i) begin
          rx_shift_next = {rx_shift_reg[46:0], sd_cmd_i};
          bit_cnt_next  = bit_cnt_reg + 6'd1;
          if (bit_cnt_reg == 6'd47) begin
            state_next = CHECK;
          end
        end
      end

      CHECK: begin
        if (cmd_ok) begin
          cmd_index_next   = rx_shift_reg[45:40];
          cmd_arg_next     = rx_shift_reg[39:8];
          cmd_valid_next   = 1'b1;
          // A strobe landing in this cycle already counts toward Ncr/timeout.
          ncr_cnt_next     = {6'd0, sd_clk_en_i};
          tmo_cnt_next     = TmoW'(sd_clk_en_i);
          rsp_latched_next = 1'b0;
          state_next       = WAIT_RSP;
        end else begin
          cmd_err_next = 1'b1;
          state_next   = IDLE;
        end
        // Back-to-back command whose start bit coincides with this cycle.
        if (start_cmd) begin
          state_next    = RX;
          bit_cnt_next  = 6'd1;
          rx_shift_next = 48'd0;
        end
      end

      WAIT_RSP: begin
        if (rsp_fire) begin
          rsp_latched_next = 1'b1;
          rsp_frame_next   = {tx_body, tx_crc_chain[40], 1'b1};
        end
        if (sd_clk_en_i) begin
          if (!sd_cmd_i) begin
            // Host started a new command: abandon any pending response.
            state_next       = RX;
            bit_cnt_next     = 6'd1;
            rx_shift_next    = 48'd0;
            rsp_latched_next = 1'b0;
          end else if (rsp_latched_reg && (ncr_cnt_reg >= NcrStart)) begin
            state_next       = TX;
            tx_shift_next    = rsp_frame_reg;
            tx_cnt_next      = 6'd0;
            rsp_latched_next = 1'b0;
          end else begin
            if (ncr_cnt_reg != 7'h7f) begin
              ncr_cnt_next = ncr_cnt_reg + 7'd1;
            end
            if (tmo_cnt_reg != TmoLimit) begin
              tmo_cnt_next = tmo_cnt_reg + TmoW'(1);
            end
            if (!rsp_latched_reg && (tmo_cnt_reg >= TmoLimit - TmoW'(1))) begin
              state_next       = IDLE;
              rsp_latched_next = 1'b0;
            end
          end
        end
      end

      TX: begin
        if (sd_clk_en_i) begin
          if (tx_cnt_reg == 6'd47) begin
            state_next = IDLE;
          end else begin
            tx_shift_next = {tx_shift_reg[46:0], 1'b1};
            tx_cnt_next   = tx_cnt_reg + 6'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register bank with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= 6'd0;
      rx_shift_reg    <= 48'd0;
      cmd_index_reg   <= 6'd0;
      cmd_arg_reg     <= 32'd0;
      cmd_valid_reg   <= 1'b0;
      cmd_err_reg     <= 1'b0;
      ncr_cnt_reg     <= 7'd0;
      tmo_cnt_reg     <= '0;
      rsp_latched_reg <= 1'b0;
      rsp_frame_reg   <= 48'd0;
      tx_shift_reg    <= 48'hffff_ffff_ffff;
      tx_cnt_reg      <= 6'd0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      rx_shift_reg    <= rx_shift_next;
      cmd_index_reg   <= cmd_index_next;
      cmd_arg_reg     <= cmd_arg_next;
      cmd_valid_reg   <= cmd_valid_next;
      cmd_err_reg     <= cmd_err_next;
      ncr_cnt_reg     <= ncr_cnt_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      rsp_latched_reg <= rsp_latched_next;
      rsp_frame_reg   <= rsp_frame_next;
      tx_shift_reg    <= tx_shift_next;
      tx_cnt_reg      <= tx_cnt_next;
    end
  end

  // The line is driven only in TX, so reset releases CMD without a clock edge.
  assign sd_cmd_en_o = (state_reg == TX);
  assign sd_cmd_o    = (state_reg == TX) ? tx_shift_reg[47] : 1'b1;
  assign busy_o      = (state_reg != IDLE);
  assign rsp_ready_o = (state_reg == WAIT_RSP) && !rsp_latched_reg;
  assign cmd_valid_o = cmd_valid_reg;
  assign cmd_err_o   = cmd_err_reg;
  assign cmd_index_o = cmd_index_reg;
  assign cmd_arg_o   = cmd_arg_reg;

endmodule
